// File: rtl/mem_mul_seq_if.sv
// Data-memory port of the shift-add multiply engine.
// Combinational read data, writes land at posedge clk.
interface mem_mul_seq_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_add;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [WIDTH-1:0]  mem_rdata;

  modport master (
    output mem_add,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_add,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output mem_rdata
  );
endinterface

// File: rtl/mem_mul_seq.sv
// Sequential shift-add multiplier: reads two words from memory,
// multiplies one bit per cycle, writes the double-width product back.
module mem_mul_seq #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a_add,
  input  logic [ADDR_W-1:0] src_b_add,
  input  logic [ADDR_W-1:0] dst_add,
  mem_mul_seq_if.master     mem,
  output logic              busy,
  output logic              done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_MUL,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]    sum;

  // State and datapath registers; reset aborts any run in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dst_q    <= dst_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RD_A;
      S_RD_A:  state_d = S_RD_B;
      S_RD_B:  state_d = S_MUL;
      S_MUL:   if (cnt_q == CNT_LAST) state_d = S_WR_LO;
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture and one shift-add step per MUL cycle.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    dst_d    = dst_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum = {1'b0, acc_q}
        + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d   = src_a_add;
          b_d   = src_b_add;
          dst_d = dst_add;
        end
      end
      S_RD_A: mcand_d = mem.mem_rdata;
      S_RD_B: begin
        mplier_d = mem.mem_rdata;
        acc_d    = '0;
        cnt_d    = '0;
      end
      S_MUL: begin
        {acc_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
      default: ;
    endcase
  end

  // Memory port and status decoded from the registered state.
  always_comb begin
    mem.mem_add   = '0;
    mem.mem_wdata = '0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      S_RD_A: begin
        mem.mem_read = 1'b1;
        mem.mem_add  = a_q;
        busy         = 1'b1;
      end
      S_RD_B: begin
        mem.mem_read = 1'b1;
        mem.mem_add  = b_q;
        busy         = 1'b1;
      end
      S_MUL: busy = 1'b1;
      S_WR_LO: begin
        mem.mem_write = 1'b1;
        mem.mem_add   = dst_q;
        mem.mem_wdata = mplier_q;
        busy          = 1'b1;
      end
      S_WR_HI: begin
        mem.mem_write = 1'b1;
        mem.mem_add   = dst_q + ADDR_W'(1);
        mem.mem_wdata = acc_q;
        busy          = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_mul_seq.sv
// Bench for mem_mul_seq: memory model, timeline reference model,
// per-cycle bus compare and directed scenarios.
module tb_mem_mul_seq;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int LAT = W + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_a_add = '0;
  logic [AW-1:0] src_b_add = '0;
  logic [AW-1:0] dst_add = '0;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  mem_mul_seq_if #(.WIDTH(W), .ADDR_W(AW)) mif ();

  mem_mul_seq #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .src_a_add(src_a_add),
    .src_b_add(src_b_add),
    .dst_add(dst_add),
    .mem(mif),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:255];
  assign mif.mem_rdata = mem[mif.mem_add[7:0]];

  always @(posedge clk)
    if (mif.mem_write) mem[mif.mem_add[7:0]] <= mif.mem_wdata;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // Reference: k = cycles since accept (0 = idle), product by plain multiply.
  int            k = 0;
  logic [AW-1:0] ea = '0, eb = '0, ed = '0;
  logic [2*W-1:0] ep = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) k <= 0;
    else if (k == 0) begin
      if (start) begin
        k  <= 1;
        ea <= src_a_add;
        eb <= src_b_add;
        ed <= dst_add;
        ep <= 64'(mem[src_a_add[7:0]]) * 64'(mem[src_b_add[7:0]]);
      end
    end else k <= (k == LAT) ? 0 : k + 1;
  end

  logic [3:0]    e_flags;
  logic [AW-1:0] e_add;
  logic [W-1:0]  e_wd;
  logic          c_add, c_wd;

  always @(negedge clk) begin
    if (rst) begin
      e_flags = 4'b0000;
      e_add = '0;
      e_wd = '0;
      c_add = 1'b1;
      c_wd = 1'b1;
      if (k == 1) begin
        e_flags = 4'b1010; e_add = ea; c_wd = 1'b0;
      end else if (k == 2) begin
        e_flags = 4'b1010; e_add = eb; c_wd = 1'b0;
      end else if (k >= 3 && k <= W + 2) begin
        e_flags = 4'b0010; c_add = 1'b0; c_wd = 1'b0;
      end else if (k == W + 3) begin
        e_flags = 4'b0110; e_add = ed; e_wd = ep[W-1:0];
      end else if (k == W + 4) begin
        e_flags = 4'b0110; e_add = ed + 1; e_wd = ep[2*W-1:W];
      end else if (k == LAT) begin
        e_flags = 4'b0001;
      end
      chk("rd_wr_busy_done",
          {mif.mem_read, mif.mem_write, busy, done}, e_flags);
      if (c_add) chk("mem_add", mif.mem_add, e_add);
      if (c_wd) chk("mem_wdata", mif.mem_wdata, e_wd);
    end
  end

  task automatic run(input logic [AW-1:0] a, input logic [AW-1:0] b,
                     input logic [AW-1:0] d, output int lat);
    @(negedge clk);
    src_a_add = a; src_b_add = b; dst_add = d; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  int lat, nd, nw, nw_rst;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #1 rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", mif.mem_read, 0);
    chk("rst_write", mif.mem_write, 0);
    chk("rst_add", mif.mem_add, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 1: 4 * 19
    mem[1] = 4; mem[2] = 19; mem[8] = 32'hDEAD; mem[9] = 32'hBEEF;
    run(1, 2, 8, lat);
    chk("t1_latency", lat, 37);
    chk("t1_lo", mem[8], 76);
    chk("t1_hi", mem[9], 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    // 2: all-ones squared
    mem[1] = 32'hFFFF_FFFF; mem[2] = 32'hFFFF_FFFF;
    run(1, 2, 10, lat);
    chk("t2_lo", mem[10], 32'h0000_0001);
    chk("t2_hi", mem[11], 32'hFFFF_FFFE);

    // 3: zero operand
    mem[3] = 0; mem[1] = 4; mem[16] = 32'h1111; mem[17] = 32'h2222;
    run(3, 1, 16, lat);
    chk("t3_latency", lat, 37);
    chk("t3_lo", mem[16], 0);
    chk("t3_hi", mem[17], 0);

    // destination wraps at top of address space
    mem[5] = 32'h0001_0001; mem[6] = 32'h0003_0000;
    mem[255] = 32'h5555; mem[0] = 32'h6666;
    run(5, 6, 32'hFFFF_FFFF, lat);
    chk("wrap_lo", mem[255], 32'h0003_0000);
    chk("wrap_hi", mem[0], 32'h0000_0003);

    // 4: start held for 60 cycles
    mem[1] = 4; mem[2] = 19; mem[30] = 32'h77; mem[31] = 32'h88;
    @(negedge clk);
    src_a_add = 1; src_b_add = 2; dst_add = 30; start = 1'b1;
    nd = 0; nw = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (mif.mem_write) nw++;
      if (i == 59) start = 1'b0;
    end
    chk("t4_runs", nd, 2);
    chk("t4_writes", nw, 4);
    chk("t4_lo", mem[30], 76);
    chk("t4_hi", mem[31], 0);

    // 5: reset during MUL cycle 10
    mem[20] = 32'hAAAA; mem[21] = 32'hBBBB;
    @(negedge clk);
    src_a_add = 1; src_b_add = 2; dst_add = 20; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_read", mif.mem_read, 0);
    chk("t5_write", mif.mem_write, 0);
    chk("t5_add", mif.mem_add, 0);
    chk("t5_wdata", mif.mem_wdata, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nw_rst = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (mif.mem_write) nw_rst++;
    end
    chk("t5_no_write", nw_rst, 0);
    chk("t5_keep_lo", mem[20], 32'hAAAA);
    chk("t5_keep_hi", mem[21], 32'hBBBB);
    mem[8] = 32'hDEAD; mem[9] = 32'hBEEF;
    run(1, 2, 8, lat);
    chk("t5_rerun_lat", lat, 37);
    chk("t5_rerun_lo", mem[8], 76);
    chk("t5_rerun_hi", mem[9], 0);

    // 6: destination aliases sources
    mem[1] = 4; mem[2] = 19;
    run(1, 2, 1, lat);
    chk("t6_lo", mem[1], 76);
    chk("t6_hi", mem[2], 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
